// File: rtl/uart_mmio_controller.sv
// uart_mmio_controller: 8N1 UART with a DATA/STATUS register interface.
// Define UART_RX_FIFO_EN to buffer received bytes in an RX_FIFO_DEPTH-entry FIFO instead of one holding register.
module uart_mmio_controller #(
    parameter int CLK_FREQ      = 70_000_000,
    parameter int BAUD          = 115200,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ack,
    input  logic       rxd,
    output logic       txd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = RX_FIFO_DEPTH;
`else
    localparam int DEPTH = (RX_FIFO_DEPTH < 1) ? RX_FIFO_DEPTH : 1;
`endif
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic            txd_q, txd_d, ack_q, ack_d, ov_q, ov_d, fe_q, fe_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [7:0]      mem_q [2**PW], mem_d [2**PW];
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic wr_data, rd_data, rd_stat, pop, push, store, fe_set, avail, full, tx_tick, rx_tick, rx_half;
    logic [7:0] status;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_data = req & we & (addr == 3'd0);
    assign rd_data = req & ~we & (addr == 3'd0);
    assign rd_stat = req & ~we & (addr == 3'd5);
    assign avail   = cnt_q != '0;
    assign full    = cnt_q == CNTW'(DEPTH);
    assign pop     = rd_data & avail;
    assign status  = {2'b00, tx_state_q == IDLE, 2'b00, fe_q, ov_q, avail};
    assign tx_tick = tx_cnt_q == CW'(DIV - 1);
    assign rx_tick = rx_cnt_q == CW'(DIV - 1);
    assign rx_half = rx_cnt_q == CW'(DIV / 2 - 1);

    always_comb begin
        ack_d   = req;
        rdata_d = rd_stat ? status : (pop ? mem_q[rd_q] : 8'h00);
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_cnt_d   = (tx_state_q == IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
        case (tx_state_q)
            IDLE: if (wr_data) begin
                tx_state_d = START;
                tx_shift_d = wdata;
                txd_d      = 1'b0;
            end
            START: if (tx_tick) begin
                tx_state_d = DATA;
                tx_bit_d   = 3'd0;
                txd_d      = tx_shift_q[0];
            end
            DATA: if (tx_tick) begin
                tx_state_d = (tx_bit_q == 3'd7) ? STOP : DATA;
                tx_bit_d   = tx_bit_q + 1'b1;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                txd_d      = (tx_bit_q == 3'd7) ? 1'b1 : tx_shift_q[1];
            end
            default: if (tx_tick) tx_state_d = IDLE;
        endcase
    end

    // START samples mid-bit; every later sample lands one bit period on.
    always_comb begin
        rx_s1_d    = rxd;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        push       = 1'b0;
        fe_set     = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = '0;
                rx_state_d = (rx_prev_q & ~rx_s2_q) ? START : IDLE;
            end
            START: if (rx_half) begin
                rx_cnt_d   = '0;
                rx_bit_d   = 3'd0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_state_d = (rx_bit_q == 3'd7) ? STOP : DATA;
            end
            default: if (rx_tick) begin
                rx_state_d = IDLE;
                push       = rx_s2_q;
                fe_set     = ~rx_s2_q;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full store still lands.
    always_comb begin
        store = push & (~full | pop);
        mem_d = mem_q;
        if (store) mem_d[wr_q] = rx_shift_q;
        wr_d  = store ? nxt(wr_q) : wr_q;
        rd_d  = pop ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CNTW'(store) - CNTW'(pop);
        ov_d  = (rd_stat ? 1'b0 : ov_q) | (push & full & ~pop);
        fe_d  = (rd_stat ? 1'b0 : fe_q) | fe_set;
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            txd_q      <= 1'b1;
            ack_q      <= 1'b0;
            rdata_q    <= 8'h00;
            ov_q       <= 1'b0;
            fe_q       <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            txd_q      <= txd_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ov_q       <= ov_d;
            fe_q       <= fe_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign txd   = txd_q;
    assign ack   = ack_q;
    assign rdata = rdata_q;
endmodule

// File: tb/tb_uart_mmio_controller.sv
// tb_uart_mmio_controller: directed tests against a cycle-level UART/register model.
module tb_uart_mmio_controller;
    localparam int DIV = 16;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, rxd = 1'b1;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       ack, txd;

    uart_mmio_controller #(.CLK_FREQ(1_600_000), .BAUD(100_000), .RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;

    logic [7:0] rxq[$];
    bit         m_ov = 0, m_fe = 0, tx_act = 0, pend_rd = 0;
    int         tx_start = 0, pend_cyc = -10;
    logic [7:0] tx_byte = 8'h00, pend_data = 8'h00;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_tx_idle(input int c);
        return !(tx_act && c >= tx_start && c < tx_start + 10 * DIV);
    endfunction

    function automatic logic m_txd(input int c);
        int i;
        if (m_tx_idle(c)) return 1'b1;
        i = (c - tx_start) / DIV;
        return (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : tx_byte[i-1];
    endfunction

    task automatic model_reset();
        rxq.delete();
        m_ov = 0; m_fe = 0; tx_act = 0; pend_cyc = -10;
    endtask

    always @(negedge clk) begin
        bit exp_ack;
        if (!rst_n) begin
            check("rst_txd", txd, 1);
            check("rst_ack", ack, 0);
            check("rst_rdata", rdata, 8'h00);
        end else begin
            exp_ack = (cyc == pend_cyc + 1);
            check("txd", txd, m_txd(cyc));
            check("ack", ack, exp_ack);
            if (exp_ack && pend_rd) check("rdata", rdata, pend_data);
        end
    end

    task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d, output logic [7:0] got);
        logic [7:0] e;
        @(posedge clk); #1;
        req = 1; we = w; addr = a; wdata = d;
        e = 8'h00;
        if (w) begin
            if (a == 3'd0 && m_tx_idle(cyc)) begin
                tx_act = 1; tx_start = cyc + 1; tx_byte = d;
            end
        end else if (a == 3'd5) begin
            e = {2'b00, m_tx_idle(cyc), 2'b00, m_fe, m_ov, rxq.size() > 0};
            m_fe = 0; m_ov = 0;
        end else if (a == 3'd0 && rxq.size() > 0) begin
            e = rxq.pop_front();
        end
        pend_cyc = cyc; pend_data = e; pend_rd = !w;
        @(posedge clk); #1;
        req = 0; we = 0;
        got = rdata;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] lit, input string nm);
        logic [7:0] got;
        bus(1'b0, a, 8'h00, got);
        check(nm, got, lit);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] got;
        bus(1'b1, a, d, got);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd = 1;
        if (!stop) m_fe = 1;
        else if (rxq.size() < DEPTH) rxq.push_back(b);
        else m_ov = 1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] fr;
        int s;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1);
        check("reset_ack", ack, 0);
        check("reset_rdata", rdata, 8'h00);
        rst_n = 1;

        rd(3'd5, 8'h20, "status_after_reset");
        wr(3'd0, 8'hA5);
        check("a5_ack", ack, 1);
        s = tx_start;
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            goto(s + i * DIV + DIV / 2);
            check("a5_bit", txd, fr[i]);
            if (i == 4) rd(3'd5, 8'h00, "status_tx_busy");
        end
        goto(s + 10 * DIV + 2);
        rd(3'd5, 8'h20, "status_tx_done");

        send_frame(8'h3C, 1);
        rd(3'd5, 8'h21, "status_rx_avail");
        rd(3'd0, 8'h3C, "data_3c");
        rd(3'd5, 8'h20, "status_rx_empty");

        rxd = 0;
        repeat (4) @(posedge clk);
        #1;
        rxd = 1;
        repeat (30) @(posedge clk);
        #1;
        rd(3'd5, 8'h20, "status_glitch");
        send_frame(8'h55, 0);
        rd(3'd5, 8'h24, "status_framing");
        rd(3'd5, 8'h20, "status_fe_cleared");

        wr(3'd3, 8'hFF);
        rd(3'd3, 8'h00, "unmapped_read");
        rd(3'd5, 8'h20, "status_unmapped_write");

        for (int b = 1; b <= DEPTH + 1; b++) send_frame(8'(b), 1);
        for (int b = 1; b <= DEPTH; b++) rd(3'd0, 8'(b), "data_overrun_seq");
        rd(3'd5, 8'h22, "status_overrun");
        rd(3'd0, 8'h00, "data_empty");
        rd(3'd5, 8'h20, "status_ov_cleared");

        wr(3'd0, 8'h33);
        s = tx_start;
        goto(s + 50);
        wr(3'd0, 8'h11);
        goto(s + 3 * DIV + DIV / 2);
        check("tx33_bit2", txd, 0);
        goto(s + 10 * DIV + 100);
        check("no_tx_11", txd, 1);
        goto(s + 10 * DIV + 300);
        rd(3'd5, 8'h20, "status_after_drop");

        @(posedge clk); #1;
        rxd = 0;
        repeat (30) @(posedge clk);
        #1;
        wr(3'd0, 8'h5A);
        goto(tx_start + 5);
        check("txd_low_before_reset", txd, 0);
        @(posedge clk); #1;
        rst_n = 0;
        rxd = 1;
        model_reset();
        #1;
        check("txd_async_reset", txd, 1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        rd(3'd5, 8'h20, "status_after_reset_rel");
        send_frame(8'h7E, 1);
        rd(3'd5, 8'h21, "status_7e_avail");
        rd(3'd0, 8'h7E, "data_7e");
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_mmio_controller.md
UART_MMIO_CONTROLLER -- requirements
Module: uart_mmio_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 70_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate; divisor DIV = CLK_FREQ/BAUD (integer floor), DIV >= 4.
REQ-003 SHALL have parameter RX_FIFO_DEPTH, default 4, power of two, used only with UART_RX_FIFO_EN.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  1  bus access request, one-cycle pulse.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; valid with req.
REQ-008 SHALL have port addr  input  3  register offset: 0 = DATA, 5 = STATUS.
REQ-009 SHALL have port wdata  input  8  write data.
REQ-010 SHALL have port rdata  output  8  read data, valid with ack.
REQ-011 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rxd  input  1  serial in, asynchronous to clk, idle high.
REQ-013 SHALL have port txd  output  1  serial out, idle high.

Function
REQ-014 SHALL assert ack exactly one cycle after each req, for one cycle, for every address; unmapped reads return 0x00, unmapped writes have no effect.
REQ-015 SHALL return in STATUS: bit0 = RX byte available, bit1 = sticky overrun, bit2 = sticky framing error, bit5 = TX idle; other bits 0.
REQ-016 SHALL clear STATUS bits 1 and 2 on a STATUS read, effective the cycle ack is driven.
REQ-017 SHALL, on a DATA write while TX idle, latch wdata and drive txd low (start bit) on the cycle after the req.
REQ-018 SHALL ignore a DATA write while TX busy (byte dropped, no error flag).
REQ-019 SHALL use TX states IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> IDLE, each bit held exactly DIV cycles; TX idle (bit5) is reasserted on the first cycle back in IDLE.
REQ-020 SHALL pass rxd through a two-flop synchronizer before any use.
REQ-021 SHALL use RX states IDLE -> START -> DATA -> STOP -> IDLE; a synchronized falling edge in IDLE enters START.
REQ-022 SHALL re-sample in START after DIV/2 cycles; a high sample is a false start and returns to IDLE with no flags changed.
REQ-023 SHALL sample each data bit and the stop bit DIV cycles after the previous sample.
REQ-024 SHALL, on a high stop bit, store the byte; on a low stop bit, discard it and set the framing error flag (bit2).
REQ-025 SHALL, on a DATA read, return the oldest stored byte and remove it; with none stored, return 0x00 and change nothing.
REQ-026 SHALL, when a byte arrives with storage full, drop the new byte and set the overrun flag (bit1), unless a DATA read removes a byte in the same cycle, in which case both the read and the store take effect and no overrun is flagged.

Reset
REQ-027 SHALL, while rst_n is low, force txd = 1, ack = 0, rdata = 0x00, both state machines to IDLE, storage empty, flags clear, synchronizer flops = 1.
REQ-028 SHALL abort any character in flight on reset assertion; after release, txd stays high until a new DATA write, and RX waits for a fresh falling edge.

Configuration
REQ-029 SHALL, with UART_RX_FIFO_EN defined, buffer RX bytes in an RX_FIFO_DEPTH-entry FIFO, in order, with full = RX_FIFO_DEPTH entries.
REQ-030 SHALL, without UART_RX_FIFO_EN, use a single holding register, where full means one byte held; all other behaviour is identical.

Verification (CLK_FREQ=1_600_000, BAUD=100_000, DIV=16)
REQ-031 SHALL check: write 0xA5 to DATA -> ack next cycle; txd low 16 cycles; then bits 1,0,1,0,0,1,0,1 at 16 cycles each; stop high; STATUS bit5 = 0 during the frame and 1 after it.
REQ-032 SHALL check: drive frame 0x3C on rxd -> STATUS reads 0x21; DATA read returns 0x3C; STATUS then reads 0x20.
REQ-033 SHALL check: glitch rxd low 4 cycles -> nothing stored, STATUS reads 0x20; frame 0x55 with low stop bit -> STATUS reads 0x24, then 0x20 on a second STATUS read.
REQ-034 SHALL check: with FIFO, send 5 bytes 0x01-0x05 without reading -> DATA reads return 0x01-0x04, STATUS bit1 = 1; without FIFO, send 2 bytes -> DATA returns 0x01, bit1 = 1.
REQ-035 SHALL check: DATA write 0x11 during an active TX frame -> the frame in flight is unchanged and 0x11 is never transmitted.
REQ-036 SHALL check: assert rst_n mid-TX frame and mid-RX frame -> txd = 1 immediately, STATUS reads 0x20 after release, and the next full frame 0x7E is received correctly.
